// File: rtl/fpadd_operand_issue.sv
// ---------------------------------------------------------------------------
// fpadd_operand_issue
//
// Operand issue and result-tracking stage in front of a pipelined FP32 adder.
// Operand pairs arrive over a valid/ready handshake into a DEPTH-entry FIFO,
// are issued at most one per cycle onto op_a/op_b (the adder's reg_A/reg_B),
// and a LAT-deep valid/tag/flag pipe runs alongside the adder so its
// valid-less `out` comes back as a tagged, valid-qualified result stream.
//
// Optional feature macro: FPADD_CLASSIFY_EN
//   defined   : operands with exponent 8'h00 or 8'hFF are flagged as special,
//               flags ride with the tag, spec_cnt counts special pairs issued
//               (saturating at 16'hFFFF).
//   undefined : no classification logic; res_flags = 0, spec_cnt = 0.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous reset, active low (0 = reset)
//   in_valid   in   operand pair offered
//   in_ready   out  FIFO not full (combinational)
//   in_a/in_b  in   FP32 operands
//   in_tag     in   user tag (TAG_W)
//   issue_en   in   issue gate; 0 stalls issue while the FIFO still fills
//   op_a/op_b  out  registered operands to the adder
//   add_out    in   adder result
//   res_valid  out  one-cycle pulse per result
//   res_data   out  add_out when res_valid, else 0
//   res_tag    out  tag of the result
//   res_flags  out  {A special, B special}
//   spec_cnt   out  saturating count of special pairs issued
//   busy       out  FIFO non-empty or any pipe stage valid
// ---------------------------------------------------------------------------
module fpadd_operand_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             issue_en,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    input  logic [31:0]      add_out,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [1:0]       res_flags,
    output logic [15:0]      spec_cnt,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // FIFO storage and pointers (extra MSB separates full from empty)
    logic [31:0]      mem_a_q   [DEPTH];
    logic [31:0]      mem_b_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty, full, push, pop;

    logic [31:0]      head_a, head_b;
    logic [TAG_W-1:0] head_tag;
    logic [1:0]       head_flags;

    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;

    // Result-tracking pipe, shifted every edge because the adder never stalls
    logic [LAT-1:0]   v_q, v_d;
    logic [TAG_W-1:0] tag_q  [LAT];
    logic [TAG_W-1:0] tag_d  [LAT];
    logic [1:0]       flag_q [LAT];
    logic [1:0]       flag_d [LAT];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && issue_en;

    assign head_a   = mem_a_q[rd_ptr_q[AW-1:0]];
    assign head_b   = mem_b_q[rd_ptr_q[AW-1:0]];
    assign head_tag = mem_tag_q[rd_ptr_q[AW-1:0]];

`ifdef FPADD_CLASSIFY_EN
    logic        a_spec, b_spec;
    logic [15:0] spec_cnt_q, spec_cnt_d;

    assign a_spec     = (head_a[30:23] == 8'h00) || (head_a[30:23] == 8'hFF);
    assign b_spec     = (head_b[30:23] == 8'h00) || (head_b[30:23] == 8'hFF);
    assign head_flags = {a_spec, b_spec};

    always_comb begin
        spec_cnt_d = spec_cnt_q;
        if (pop && (|head_flags) && (spec_cnt_q != 16'hFFFF)) begin
            spec_cnt_d = spec_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spec_cnt_q <= 16'h0000;
        end else begin
            spec_cnt_q <= spec_cnt_d;
        end
    end

    assign spec_cnt = spec_cnt_q;
`else
    assign head_flags = 2'b00;
    assign spec_cnt   = 16'h0000;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            op_a_d   = head_a;
            op_b_d   = head_b;
        end
    end

    always_comb begin
        v_d       = '0;
        v_d[0]    = pop;
        tag_d[0]  = pop ? head_tag : '0;
        flag_d[0] = pop ? head_flags : 2'b00;
        for (int i = 1; i < LAT; i++) begin
            v_d[i]    = v_q[i-1];
            tag_d[i]  = tag_q[i-1];
            flag_d[i] = flag_q[i-1];
        end
    end

    // Storage carries no reset: entries are only read behind a valid pointer
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q[AW-1:0]]   <= in_a;
            mem_b_q[wr_ptr_q[AW-1:0]]   <= in_b;
            mem_tag_q[wr_ptr_q[AW-1:0]] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            op_a_q   <= 32'h0000_0000;
            op_b_q   <= 32'h0000_0000;
            v_q      <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i]  <= '0;
                flag_q[i] <= 2'b00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            v_q      <= v_d;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i]  <= tag_d[i];
                flag_q[i] <= flag_d[i];
            end
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign res_valid = v_q[LAT-1];
    assign res_tag   = tag_q[LAT-1];
    assign res_flags = flag_q[LAT-1];
    assign res_data  = res_valid ? add_out : 32'h0000_0000;
    assign busy      = !empty || (|v_q);

endmodule
